pixel_source: RTL



---
 rtl/gpu_pkg.sv | 32 +++
 rtl/cell_ram.sv | 24 ++
 rtl/pixel_source.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/gpu_pkg.sv
// Shared constants for the pixel_source framebuffer: geometry defaults,
// instruction field layout, opcodes and the instruction FSM states.
package gpu_pkg;

  localparam int COLS_DEFAULT  = 30;
  localparam int ROWS_DEFAULT  = 48;
  localparam int LINES_DEFAULT = 10;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_WRITE = 4'h1;
  localparam logic [3:0] OP_FILL  = 4'h2;

  localparam int OP_MSB    = 31;
  localparam int OP_LSB    = 28;
  localparam int ROW_MSB   = 27;
  localparam int ROW_LSB   = 22;
  localparam int COL_MSB   = 21;
  localparam int COL_LSB   = 17;
  localparam int COLOR_MSB = 11;
  localparam int COLOR_LSB = 0;

  localparam int ROW_FIELD_W   = ROW_MSB - ROW_LSB + 1;
  localparam int COL_FIELD_W   = COL_MSB - COL_LSB + 1;
  localparam int COLOR_FIELD_W = COLOR_MSB - COLOR_LSB + 1;

  typedef enum logic [1:0] {
    IDLE,
    WRITE_PEND,
    FILLING
  } state_t;

endpackage

// File: rtl/cell_ram.sv
// Single-port synchronous framebuffer RAM; rdata is the registered contents
// of addr as it was before any write in the same cycle.
module cell_ram #(
  parameter int DEPTH  = 1440,
  parameter int ADDR_W = 11,
  parameter int DATA_W = 12
) (
  input  logic              i_clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/pixel_source.sv
// Framebuffer front end for the signal generator: scan counters that follow the
// pixel strobes, GPU instruction decode, and read-priority RAM port sharing.
module pixel_source
  import gpu_pkg::*;
#(
  parameter int COLS          = COLS_DEFAULT,
  parameter int ROWS          = ROWS_DEFAULT,
  parameter int LINES_PER_ROW = LINES_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_screen_reset,
  input  logic        i_pixel_x_clock,
  input  logic        i_pixel_y_clock,
  input  logic [31:0] i_instruction,
  input  logic        i_instruction_ready,
  output logic        o_busy,
  output logic [11:0] o_color
);

  localparam int CELLS  = ROWS * COLS;
  localparam int ADDR_W = $clog2(CELLS);
  localparam int COL_W  = $clog2(COLS + 1);
  localparam int ROW_W  = $clog2(ROWS + 1);
  localparam int LINE_W = (LINES_PER_ROW > 1) ? $clog2(LINES_PER_ROW) : 1;

  logic [COL_W-1:0]  col_reg;
  logic [ROW_W-1:0]  row_reg;
  logic [LINE_W-1:0] line_reg;
  logic [ADDR_W-1:0] base_reg;

  state_t            state_reg;
  logic              busy_reg;
  logic [ADDR_W-1:0] fill_addr_reg;
  logic [ADDR_W-1:0] pend_addr_reg;
  logic [11:0]       wr_color_reg;

  logic              rd_pending_reg;
  logic [11:0]       color_reg;

  logic [COL_W-1:0]  scan_col;
  logic [ROW_W-1:0]  scan_row;
  logic [ADDR_W-1:0] scan_base;
  logic              rd_hit;
  logic [ADDR_W-1:0] rd_addr;

  logic              wr_req;
  logic              wr_go;
  logic [ADDR_W-1:0] wr_addr;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [11:0]       ram_rdata;

  logic [3:0]             opcode;
  logic [ROW_FIELD_W-1:0] ins_row;
  logic [COL_FIELD_W-1:0] ins_col;
  logic [11:0]            ins_color;
  logic                   ins_in_range;
  logic                   accept;
  logic                   unused_ins_bits;

  assign opcode          = i_instruction[OP_MSB:OP_LSB];
  assign ins_row         = i_instruction[ROW_MSB:ROW_LSB];
  assign ins_col         = i_instruction[COL_MSB:COL_LSB];
  assign ins_color       = i_instruction[COLOR_MSB:COLOR_LSB];
  assign unused_ins_bits = ^i_instruction[COL_LSB-1:COLOR_MSB+1];
  assign ins_in_range    = (int'(ins_row) < ROWS) && (int'(ins_col) < COLS);

  // A screen reset in the same cycle as an x-strobe reads from the top-left cell.
  always_comb begin
    scan_col  = i_screen_reset ? '0 : col_reg;
    scan_row  = i_screen_reset ? '0 : row_reg;
    scan_base = i_screen_reset ? '0 : base_reg;
    rd_hit    = i_pixel_x_clock && (int'(scan_col) < COLS) && (int'(scan_row) < ROWS);
    rd_addr   = scan_base + ADDR_W'(scan_col);
  end

  always_comb begin
    wr_req  = 1'b0;
    wr_addr = pend_addr_reg;
    case (state_reg)
      WRITE_PEND: wr_req = 1'b1;
      FILLING: begin
        wr_req  = 1'b1;
        wr_addr = fill_addr_reg;
      end
      default: wr_req = 1'b0;
    endcase
    // Reads own the port; a reset edge must not land one more fill write.
    wr_go    = wr_req && !rd_hit && i_reset_n;
    ram_we   = wr_go;
    ram_addr = rd_hit ? rd_addr : wr_addr;
    accept   = i_instruction_ready && !busy_reg &&
               ((state_reg == IDLE) || ((state_reg == WRITE_PEND) && wr_go));
  end

  cell_ram #(
    .DEPTH  (CELLS),
    .ADDR_W (ADDR_W),
    .DATA_W (12)
  ) u_cell_ram (
    .i_clk (i_clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (wr_color_reg),
    .rdata (ram_rdata)
  );

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      col_reg  <= '0;
      row_reg  <= '0;
      line_reg <= '0;
      base_reg <= '0;
    end else if (i_screen_reset) begin
      col_reg  <= rd_hit ? COL_W'(1) : '0;
      row_reg  <= '0;
      line_reg <= '0;
      base_reg <= '0;
    end else begin
      if (i_pixel_x_clock) begin
        col_reg <= rd_hit ? col_reg + 1'b1 : COL_W'(COLS);
      end
      if (i_pixel_y_clock) begin
        col_reg <= '0;
        if (int'(line_reg) == LINES_PER_ROW - 1) begin
          line_reg <= '0;
          if (int'(row_reg) < ROWS) begin
            row_reg  <= row_reg + 1'b1;
            base_reg <= base_reg + ADDR_W'(COLS);
          end
        end else begin
          line_reg <= line_reg + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_reg     <= IDLE;
      busy_reg      <= 1'b0;
      fill_addr_reg <= '0;
    end else begin
      case (state_reg)
        WRITE_PEND: if (wr_go) state_reg <= IDLE;
        FILLING: begin
          if (wr_go) begin
            if (fill_addr_reg == ADDR_W'(CELLS - 1)) begin
              state_reg <= IDLE;
              busy_reg  <= 1'b0;
            end else begin
              fill_addr_reg <= fill_addr_reg + 1'b1;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
      // A WRITE_PEND commit cycle can take the next instruction directly.
      if (accept) begin
        if (opcode == OP_WRITE && ins_in_range) begin
          state_reg     <= WRITE_PEND;
          pend_addr_reg <= ADDR_W'(ins_row) * ADDR_W'(COLS) + ADDR_W'(ins_col);
          wr_color_reg  <= ins_color;
        end else if (opcode == OP_FILL) begin
          state_reg     <= FILLING;
          busy_reg      <= 1'b1;
          fill_addr_reg <= '0;
          wr_color_reg  <= ins_color;
        end
      end
    end
  end

  // color_reg remembers the last presented colour so RAM traffic between strobes is invisible.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      color_reg      <= '0;
      rd_pending_reg <= 1'b0;
    end else begin
      color_reg      <= (i_pixel_x_clock && !rd_hit) ? 12'h000 : o_color;
      rd_pending_reg <= rd_hit;
    end
  end

  assign o_color = rd_pending_reg ? ram_rdata : color_reg;
  assign o_busy  = busy_reg;

endmodule
